// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for imem fetch, dmem read and dmem write, with PUTC/EXIT MMIO decode.
// Grants are combinational; read data returns one cycle after grant under a registered return tag.
module mem_arbiter #(
  parameter int          MAW          = 15,
  parameter int          STARVE_LIMIT = 4,
  parameter logic [31:0] PUTC_ADDR    = 32'h8000001c,
  parameter logic [31:0] EXIT_ADDR    = 32'h8000002c
) (
  input  logic           clk,
  input  logic           resetb,
  input  logic           imem_req,
  input  logic [31:0]    imem_addr,
  output logic           imem_gnt,
  output logic           imem_rvalid,
  output logic [31:0]    imem_rdata,
  input  logic           dmem_rreq,
  input  logic [31:0]    dmem_raddr,
  output logic           dmem_rgnt,
  output logic           dmem_rvalid,
  output logic [31:0]    dmem_rdata,
  input  logic           dmem_wreq,
  input  logic [31:0]    dmem_waddr,
  input  logic [31:0]    dmem_wdata,
  input  logic [3:0]     dmem_wstrb,
  output logic           dmem_wgnt,
  output logic           mem_re,
  output logic           mem_we,
  output logic [MAW-1:0] mem_addr,
  output logic [31:0]    mem_wdata,
  output logic [3:0]     mem_wstrb,
  input  logic [31:0]    mem_rdata,
  output logic           putc_valid,
  output logic [7:0]     putc_char,
  output logic           exit_valid,
  output logic           range_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {TAG_NONE, TAG_IMEM, TAG_DMEM, TAG_ZERO} tag_t;

  tag_t          tag;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   imem_rdata_q;
  logic [31:0]   dmem_rdata_q;

  logic w_mmio, w_ram, r_ram, starved, w_ram_req;
  logic w_ram_gnt, w_free_gnt;

  logic unused_bits;
  assign unused_bits = ^{imem_addr[31:MAW+2], imem_addr[1:0], dmem_raddr[1:0]};

  always_comb begin
    w_mmio     = (dmem_waddr == PUTC_ADDR) || (dmem_waddr == EXIT_ADDR);
    w_ram      = (dmem_waddr[31:MAW+2] == '0);
    r_ram      = (dmem_raddr[31:MAW+2] == '0);
    starved    = imem_req && (starve_cnt == SW'(STARVE_LIMIT));
    w_ram_req  = dmem_wreq && !w_mmio && w_ram;
    // MMIO and out-of-range writes never touch the RAM, so they bypass arbitration.
    w_free_gnt = dmem_wreq && !w_ram_req;
    w_ram_gnt  = w_ram_req && !starved;
    dmem_wgnt  = w_ram_gnt || w_free_gnt;
    // An out-of-range read still occupies the return slot, so it blocks a low-priority fetch.
    dmem_rgnt  = dmem_rreq && !starved && (!r_ram || !w_ram_req);
    imem_gnt   = imem_req && (starved || (!w_ram_req && !dmem_rreq));

    mem_re    = imem_gnt || (dmem_rgnt && r_ram);
    mem_we    = w_ram_gnt;
    mem_wdata = w_ram_gnt ? dmem_wdata : 32'h0;
    mem_wstrb = w_ram_gnt ? dmem_wstrb : 4'h0;
    mem_addr  = '0;
    if (imem_gnt)
      mem_addr = imem_addr[MAW+1:2];
    else if (dmem_rgnt && r_ram)
      mem_addr = dmem_raddr[MAW+1:2];
    else if (w_ram_gnt)
      mem_addr = dmem_waddr[MAW+1:2];
  end

  always_comb begin
    imem_rvalid = (tag == TAG_IMEM);
    dmem_rvalid = (tag == TAG_DMEM) || (tag == TAG_ZERO);
    imem_rdata  = imem_rvalid ? mem_rdata : imem_rdata_q;
    dmem_rdata  = (tag == TAG_DMEM) ? mem_rdata :
                  (tag == TAG_ZERO) ? 32'h0 : dmem_rdata_q;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      tag          <= TAG_NONE;
      starve_cnt   <= '0;
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
      putc_valid   <= 1'b0;
      putc_char    <= 8'h0;
      exit_valid   <= 1'b0;
      range_err    <= 1'b0;
    end else begin
      if (imem_gnt)
        tag <= TAG_IMEM;
      else if (dmem_rgnt)
        tag <= r_ram ? TAG_DMEM : TAG_ZERO;
      else
        tag <= TAG_NONE;

      if (!imem_req || imem_gnt)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;

      if (tag == TAG_IMEM)
        imem_rdata_q <= mem_rdata;
      if (tag == TAG_DMEM)
        dmem_rdata_q <= mem_rdata;
      else if (tag == TAG_ZERO)
        dmem_rdata_q <= 32'h0;

      putc_valid <= dmem_wreq && (dmem_waddr == PUTC_ADDR);
      exit_valid <= dmem_wreq && (dmem_waddr == EXIT_ADDR);
      if (dmem_wreq && (dmem_waddr == PUTC_ADDR))
        putc_char <= dmem_wdata[7:0];

      if ((w_free_gnt && !w_mmio) || (dmem_rgnt && !r_ram))
        range_err <= 1'b1;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one synchronous-read RAM between the core's instruction-fetch port, data-read port and data-write port. It also decodes the PUTC/EXIT MMIO words and flags out-of-range data accesses. It sits between the riscv core and a single-port RAM, replacing the two-RAM arrangement in unified-memory builds.

## Interface
- MAW, 15: RAM word-address width (2^MAW words of 32 bits; default 128 KB)
- STARVE_LIMIT, 4: consecutive lost cycles after which imem wins arbitration
- PUTC_ADDR, 32'h8000001c: MMIO console byte address
- EXIT_ADDR, 32'h8000002c: MMIO exit address

Ports:
- clk  in  1  clock, all state on rising edge
- resetb  in  1  asynchronous active-low reset
- imem_req  in  1  fetch request; hold with imem_addr stable until imem_gnt
- imem_addr  in  32  fetch byte address
- imem_gnt  out  1  fetch accepted this cycle (combinational)
- imem_rvalid  out  1  imem_rdata valid (registered)
- imem_rdata  out  32  fetch data
- dmem_rreq / dmem_raddr / dmem_rgnt / dmem_rvalid / dmem_rdata  same widths and rules as imem, for data reads
- dmem_wreq  in  1  write request; hold until dmem_wgnt
- dmem_waddr  in  32  write byte address
- dmem_wdata  in  32  write data
- dmem_wstrb  in  4  byte enables
- dmem_wgnt  out  1  write accepted this cycle (combinational)
- mem_re, mem_we  out  1  RAM read/write enable (at most one high)
- mem_addr  out  MAW  RAM word address (= byte address [MAW+1:2])
- mem_wdata  out  32, mem_wstrb  out  4  RAM write data and enables
- mem_rdata  in  32  RAM data, one cycle after mem_re
- putc_valid  out  1  one-cycle pulse, console byte written
- putc_char  out  8  byte written to PUTC_ADDR (wdata[7:0])
- exit_valid  out  1  one-cycle pulse, EXIT written
- range_err  out  1  sticky out-of-range flag

## Operation
- Address classes: MMIO is waddr == PUTC_ADDR or EXIT_ADDR (writes only). RAM is addr[31:MAW+2] == 0. Any other address is out of range.
- MMIO write: dmem_wgnt is asserted in the same cycle, regardless of RAM arbitration, and consumes no RAM slot. putc_valid/putc_char or exit_valid are registered the next cycle.
- Out-of-range write: granted the same cycle, no RAM slot used, range_err set.
- Out-of-range read: granted the same cycle, no RAM slot used, rvalid next cycle with rdata = 0, range_err set.
- RAM slot, one grant per cycle, in priority order:
  - imem, if starve_cnt == STARVE_LIMIT
  - otherwise RAM write, then dmem read, then imem.
- starve_cnt (width $clog2(STARVE_LIMIT+1)):
  - increments while imem_req is high and imem_gnt is low, saturating at STARVE_LIMIT
  - clears on imem_gnt or when imem_req is low.
- Read grant: drives mem_re and mem_addr, and registers a 2-bit return tag (none/imem/dmem/zero). Next cycle the tagged port gets rvalid = 1 and rdata = mem_rdata (or 0 for the zero tag). The non-tagged rdata holds its last value.
- Write grant: drives mem_we, mem_addr, mem_wdata and mem_wstrb the same cycle. There is no response beyond wgnt.
- Idle cycles: mem_re = mem_we = 0 and mem_addr = 0.
- range_err clears only on reset.

## Timing
- Reset (async, resetb low):
  - all registered outputs clear: rvalids, rdatas = 0, putc_valid = 0, putc_char = 0, exit_valid = 0, range_err = 0
  - starve_cnt = 0, tag = none
  - a return in flight when reset asserts is dropped.
- Grants are combinational from requests and registered state. There is no combinational path from mem_rdata to any gnt.
- Read latency: gnt in cycle N, rvalid in cycle N+1. Back-to-back grants to the same port give rvalid on consecutive cycles, so full throughput is 1 read/cycle.
- Simultaneous MMIO write with a RAM read: both are granted in the same cycle.
- Simultaneous RAM write, dmem read and imem request: the write is granted, then the read the next cycle, then imem. If imem has already starved STARVE_LIMIT cycles, imem goes first.
- A requester dropping its req before gnt is legal; it produces no side effects.

## Test plan
- Reset mid-read: imem gnt in cycle N, resetb low in N+1 → imem_rvalid stays 0; all outputs return to reset values.
- Fetch alone: imem_req with addr 0x100, RAM word 0x40 = 0x00000013 → imem_gnt the same cycle, mem_addr = 0x40, imem_rvalid next cycle with data 0x00000013.
- Contention: wreq (0x200, data 0xdeadbeef, strb 0xf), rreq (0x204) and imem_req held → grant order is write, dmem read, imem on consecutive cycles, with mem_addr 0x80, 0x81, then the imem word.
- Starvation: wreq and rreq each reasserted every cycle with imem_req held → imem granted on the 5th cycle (STARVE_LIMIT = 4), then starve_cnt = 0.
- MMIO: write 0x41 to 0x8000001c while dmem read of 0x10 is granted → both gnts high; putc_valid = 1 with putc_char = 0x41 next cycle. Write to 0x8000002c → exit_valid pulse; mem_we stays 0.
- Range: read 0x00040000 → rvalid next cycle with rdata 0 and range_err = 1; range_err stays 1 after later legal accesses until reset.
